// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program load port, run/redirect controls and the decoder handshake.
// master = fetch stage, slave = the surrounding control/decoder side.
interface instr_fetch_if #(
  parameter int AW = 5
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          run;
  logic          redirect_en;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] pc;
  logic          halted;
  logic [15:0]   fetch_count;

  modport master (
    input  prog_we, prog_addr, prog_data, run, redirect_en, redirect_pc, instr_ready,
    output instr, instr_valid, pc, halted, fetch_count
  );

  modport slave (
    output prog_we, prog_addr, prog_data, run, redirect_en, redirect_pc, instr_ready,
    input  instr, instr_valid, pc, halted, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: program memory + PC, one word per FETCH/HOLD pair under valid/ready.
// Redirect flushes the held word; a HALT_OP word is delivered, counted, then execution stops.
module instr_fetch #(
  parameter int            AW         = 5,
  parameter logic [AW-1:0] START_ADDR = '0,
  parameter logic [3:0]    HALT_OP    = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   fetch_word;
  logic          mem_we;
  logic          accept;

  // Memory is deliberately outside the reset domain so a program survives rst.
  assign mem_we = (state_q == IDLE) && bus.prog_we && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign fetch_word = mem[pc_q];
  assign accept     = valid_q && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALT: begin
        valid_d = 1'b0;
        if (bus.run) begin
          pc_d    = START_ADDR;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (bus.redirect_en) begin
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end else begin
          instr_d = fetch_word;
          valid_d = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Redirect wins over a same-cycle accept: the flushed word is never counted.
        if (bus.redirect_en) begin
          pc_d    = bus.redirect_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (accept) begin
          valid_d = 1'b0;
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          state_d = (instr_q[31:28] == HALT_OP) ? HALT : FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stream, backpressure, redirect, write-lockout/reset, PC wrap.
module tb_instr_fetch;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] p [0:2];
  logic [31:0] got [0:7];
  logic [31:0] held;

  instr_fetch_if #(.AW(5)) ifa ();
  instr_fetch_if #(.AW(5)) ifb ();

  instr_fetch #(.AW(5), .START_ADDR(5'd0), .HALT_OP(4'hF)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  instr_fetch #(.AW(5), .START_ADDR(5'd31), .HALT_OP(4'hF)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [4:0] a, input logic [31:0] d);
    ifa.prog_we   = 1'b1;
    ifa.prog_addr = a;
    ifa.prog_data = d;
    step();
    ifa.prog_we   = 1'b0;
  endtask

  // Gathers accepted words (ready held high) until halt or the cycle budget runs out.
  task automatic collect_a(input int maxc, output int n, output int bad_gap);
    int last;
    n = 0;
    bad_gap = 0;
    last = -1;
    for (int c = 0; c < maxc && !ifa.halted; c++) begin
      step();
      if (ifa.instr_valid && ifa.instr_ready) begin
        if (n < 8) got[n] = ifa.instr;
        if (last >= 0 && (c - last) != 2) bad_gap++;
        last = c;
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ifa.instr_valid); end
    checks++; if (ifa.instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", ifa.instr); end
    checks++; if (ifa.pc !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", ifa.pc); end
    checks++; if (ifa.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", ifa.halted); end
    checks++; if (ifa.fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ifa.fetch_count); end
    checks++; if (ifb.pc !== 5'd31) begin errors++; $display("FAIL reset_pc_start got %0d want 31", ifb.pc); end
  endtask

  task automatic test_stream();
    int n, bad;
    load_a(5'd0, p[0]);
    load_a(5'd1, p[1]);
    load_a(5'd2, p[2]);
    load_a(5'd5, 32'h5000_0005);
    load_a(5'd6, 32'hF000_0006);
    ifa.instr_ready = 1'b1;
    ifa.run = 1'b1;
    step();
    ifa.run = 1'b0;
    collect_a(30, n, bad);
    checks++; if (n !== 3) begin errors++; $display("FAIL stream_words got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== p[i]) begin errors++; $display("FAIL stream_word%0d got %h want %h", i, got[i], p[i]); end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stream_gap got %0d bad gaps want 0", bad); end
    checks++; if (ifa.halted !== 1'b1) begin errors++; $display("FAIL stream_halted got %0b want 1", ifa.halted); end
    checks++; if (ifa.fetch_count !== 16'd3) begin errors++; $display("FAIL stream_count got %0d want 3", ifa.fetch_count); end
    checks++; if (ifa.pc !== 5'd3) begin errors++; $display("FAIL stream_pc got %0d want 3", ifa.pc); end
    step();
    checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %0b want 0", ifa.instr_valid); end
    checks++; if (ifa.pc !== 5'd3) begin errors++; $display("FAIL halt_pc_frozen got %0d want 3", ifa.pc); end
  endtask

  task automatic test_backpressure();
    ifa.instr_ready = 1'b0;
    ifa.run = 1'b1;
    step();
    ifa.run = 1'b0;
    step();
    checks++; if (ifa.instr !== p[0]) begin errors++; $display("FAIL bp_first got %h want %h", ifa.instr, p[0]); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ifa.instr !== p[0] || ifa.instr_valid !== 1'b1 || ifa.pc !== 5'd1 || ifa.fetch_count !== 16'd0) begin
        errors++;
        $display("FAIL bp_hold%0d got instr=%h vld=%0b pc=%0d cnt=%0d want %h 1 1 0",
                 i, ifa.instr, ifa.instr_valid, ifa.pc, ifa.fetch_count, p[0]);
      end
    end
    ifa.instr_ready = 1'b1;
    step();
    ifa.instr_ready = 1'b0;
    checks++; if (ifa.instr_valid !== 1'b0 || ifa.fetch_count !== 16'd1) begin
      errors++; $display("FAIL bp_accept got vld=%0b cnt=%0d want 0 1", ifa.instr_valid, ifa.fetch_count); end
    step();
    checks++; if (ifa.instr !== p[1] || ifa.pc !== 5'd2 || ifa.fetch_count !== 16'd1) begin
      errors++; $display("FAIL bp_next got instr=%h pc=%0d cnt=%0d want %h 2 1", ifa.instr, ifa.pc, ifa.fetch_count, p[1]); end
  endtask

  task automatic test_redirect();
    ifa.redirect_en = 1'b1;
    ifa.redirect_pc = 5'd5;
    ifa.instr_ready = 1'b1;
    step();
    ifa.redirect_en = 1'b0;
    checks++; if (ifa.instr_valid !== 1'b0 || ifa.pc !== 5'd5 || ifa.fetch_count !== 16'd1) begin
      errors++; $display("FAIL redir_flush got vld=%0b pc=%0d cnt=%0d want 0 5 1", ifa.instr_valid, ifa.pc, ifa.fetch_count); end
    step();
    checks++; if (ifa.instr_valid !== 1'b1 || ifa.instr !== 32'h5000_0005 || ifa.pc !== 5'd6) begin
      errors++; $display("FAIL redir_target got vld=%0b instr=%h pc=%0d want 1 50000005 6", ifa.instr_valid, ifa.instr, ifa.pc); end
    step();
    checks++; if (ifa.fetch_count !== 16'd2) begin errors++; $display("FAIL redir_count got %0d want 2", ifa.fetch_count); end
    step();
    checks++; if (ifa.instr !== 32'hF000_0006) begin errors++; $display("FAIL redir_halt_word got %h want f0000006", ifa.instr); end
    step();
    checks++; if (ifa.halted !== 1'b1 || ifa.fetch_count !== 16'd3 || ifa.pc !== 5'd7) begin
      errors++; $display("FAIL redir_halt got halted=%0b cnt=%0d pc=%0d want 1 3 7", ifa.halted, ifa.fetch_count, ifa.pc); end
  endtask

  task automatic test_prog_hold_rst();
    int n, bad;
    ifa.instr_ready = 1'b0;
    ifa.run = 1'b1;
    step();
    ifa.run = 1'b0;
    step();
    held = ifa.instr;
    ifa.prog_we   = 1'b1;
    ifa.prog_addr = 5'd0;
    ifa.prog_data = 32'hDEAD_BEEF;
    step();
    step();
    ifa.prog_we = 1'b0;
    checks++; if (ifa.instr_valid !== 1'b1 || held !== p[0]) begin
      errors++; $display("FAIL hold_word got vld=%0b instr=%h want 1 %h", ifa.instr_valid, held, p[0]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ifa.instr_valid !== 1'b0 || ifa.pc !== 5'd0 || ifa.halted !== 1'b0 || ifa.fetch_count !== 16'd0) begin
      errors++; $display("FAIL midrst got vld=%0b pc=%0d halted=%0b cnt=%0d want 0 0 0 0",
                         ifa.instr_valid, ifa.pc, ifa.halted, ifa.fetch_count); end
    step();
    checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got vld=%0b want 0", ifa.instr_valid); end
    ifa.instr_ready = 1'b1;
    ifa.run = 1'b1;
    step();
    ifa.run = 1'b0;
    collect_a(30, n, bad);
    checks++; if (n !== 3) begin errors++; $display("FAIL rerun_words got %0d want 3", n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== p[i]) begin errors++; $display("FAIL rerun_word%0d got %h want %h", i, got[i], p[i]); end
    end
    checks++; if (ifa.halted !== 1'b1 || ifa.fetch_count !== 16'd3) begin
      errors++; $display("FAIL rerun_halt got halted=%0b cnt=%0d want 1 3", ifa.halted, ifa.fetch_count); end
  endtask

  task automatic test_wrap();
    ifb.prog_we   = 1'b1;
    ifb.prog_addr = 5'd31;
    ifb.prog_data = 32'h1000_001F;
    step();
    ifb.prog_addr = 5'd0;
    ifb.prog_data = 32'hF000_0000;
    step();
    ifb.prog_we = 1'b0;
    ifb.instr_ready = 1'b1;
    ifb.run = 1'b1;
    step();
    ifb.run = 1'b0;
    step();
    checks++; if (ifb.instr_valid !== 1'b1 || ifb.instr !== 32'h1000_001F || ifb.pc !== 5'd0) begin
      errors++; $display("FAIL wrap_first got vld=%0b instr=%h pc=%0d want 1 1000001f 0", ifb.instr_valid, ifb.instr, ifb.pc); end
    step();
    step();
    checks++; if (ifb.instr_valid !== 1'b1 || ifb.instr !== 32'hF000_0000 || ifb.pc !== 5'd1) begin
      errors++; $display("FAIL wrap_second got vld=%0b instr=%h pc=%0d want 1 f0000000 1", ifb.instr_valid, ifb.instr, ifb.pc); end
    step();
    checks++; if (ifb.halted !== 1'b1 || ifb.fetch_count !== 16'd2) begin
      errors++; $display("FAIL wrap_halt got halted=%0b cnt=%0d want 1 2", ifb.halted, ifb.fetch_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    p[0] = 32'h1000_0421;
    p[1] = 32'h2000_8C62;
    p[2] = 32'hF000_0000;
    rst = 1'b1;
    ifa.prog_we = 1'b0; ifa.prog_addr = '0; ifa.prog_data = '0; ifa.run = 1'b0;
    ifa.redirect_en = 1'b0; ifa.redirect_pc = '0; ifa.instr_ready = 1'b0;
    ifb.prog_we = 1'b0; ifb.prog_addr = '0; ifb.prog_data = '0; ifb.run = 1'b0;
    ifb.redirect_en = 1'b0; ifb.redirect_pc = '0; ifb.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_prog_hold_rst();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
